// File: rtl/parking_pkg.sv
// Shared constants and helpers for the parking occupancy counter.
//   DEFAULT_CAPACITY : default maximum vehicle count
//   DEFAULT_N_LANES  : default number of gate lanes
//   MAX_LANES        : widest lane vector any instance may use
//   REJ_W            : width of the saturating rejection counter
//   popcount()       : number of set bits in a MAX_LANES-wide vector
package parking_pkg;

    localparam int unsigned DEFAULT_CAPACITY = 99;
    localparam int unsigned DEFAULT_N_LANES  = 2;
    localparam int unsigned MAX_LANES        = 8;
    localparam int unsigned REJ_W            = 16;

    function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lane_grant_arbiter.sv
// Fixed-priority gate arbiter: lane 0 is served first, and a requesting lane is
// granted while the number of grants handed out so far is below the free space.
// Ports:
//   req   : per-lane entry requests
//   space : number of vehicles that may still enter this cycle
//   grant : per-lane gate-open grants (combinational)
module lane_grant_arbiter #(
    parameter int unsigned N_LANES = 2,
    parameter int unsigned SW      = 11
) (
    input  logic [N_LANES-1:0] req,
    input  logic [SW-1:0]      space,
    output logic [N_LANES-1:0] grant
);

    logic [SW-1:0] granted;

    always_comb begin
        granted = '0;
        grant   = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (req[i] && (granted < space)) begin
                grant[i] = 1'b1;
                granted  = granted + SW'(1);
            end
        end
    end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter with per-lane entry gates and exit sensors.
// Ports:
//   clk, reset_n       : clock (rising edge) and asynchronous active-low reset
//   clear              : synchronous clear of count, rejected_cnt, underflow_err
//   load_en, load_val  : synchronous preset of count (clamped to CAPACITY)
//   entry_req          : per-lane entry requests, one vehicle per bit per cycle
//   exit_evt           : per-lane exit events, one vehicle per bit per cycle
//   entry_grant        : same-cycle gate-open grants
//   count              : registered occupancy
//   full/empty/almost_full : status decoded from the registered count
//   rejected_cnt       : saturating count of refused entries
//   underflow_err      : sticky, set when exits exceed the occupancy
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY  = DEFAULT_CAPACITY,
    parameter int unsigned N_LANES   = DEFAULT_N_LANES,
    parameter int unsigned ALMOST_TH = CAPACITY - 5,
    localparam int unsigned CW       = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load_en,
    input  logic [CW-1:0]      load_val,
    input  logic [N_LANES-1:0] entry_req,
    input  logic [N_LANES-1:0] exit_evt,
    output logic [N_LANES-1:0] entry_grant,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic [REJ_W-1:0]   rejected_cnt,
    output logic               underflow_err
);

    // Wide enough that CAPACITY + exits never wraps.
    localparam int unsigned AW = CW + 4;

    function automatic logic [3:0] lanes_pop(input logic [N_LANES-1:0] v);
        logic [MAX_LANES-1:0] p;
        p = '0;
        p[N_LANES-1:0] = v;
        return popcount(p);
    endfunction

    logic [CW-1:0]      count_q, count_d;
    logic [REJ_W-1:0]   rej_q, rej_d;
    logic               uerr_q, uerr_d;

    logic               normal;
    logic [N_LANES-1:0] req_masked;
    logic [N_LANES-1:0] grant;
    logic [AW-1:0]      count_ext;
    logic [AW-1:0]      exit_n;
    logic [AW-1:0]      valid_exits;
    logic [AW-1:0]      space;
    logic [AW-1:0]      count_next;
    logic [AW-1:0]      load_ext;
    logic [REJ_W:0]     rej_sum;

    assign normal    = !clear && !load_en;
    // Requests are masked during clear/load and while reset is held, so the
    // gates stay shut without the arbiter needing to know why.
    assign req_masked = (normal && reset_n) ? entry_req : '0;

    assign count_ext   = AW'(count_q);
    assign exit_n      = AW'(lanes_pop(exit_evt));
    assign valid_exits = (exit_n > count_ext) ? count_ext : exit_n;
    // Spaces freed by this cycle's exits can be handed straight to entries.
    assign space       = AW'(CAPACITY) - count_ext + valid_exits;

    lane_grant_arbiter #(
        .N_LANES (N_LANES),
        .SW      (AW)
    ) u_arbiter (
        .req   (req_masked),
        .space (space),
        .grant (grant)
    );

    assign entry_grant = grant;
    assign count_next  = count_ext - valid_exits + AW'(lanes_pop(grant));
    assign load_ext    = AW'(load_val);
    assign rej_sum     = {1'b0, rej_q} + (REJ_W + 1)'(lanes_pop(entry_req & ~grant));

    always_comb begin
        count_d = count_q;
        rej_d   = rej_q;
        uerr_d  = uerr_q;
        if (clear) begin
            count_d = '0;
            rej_d   = '0;
            uerr_d  = 1'b0;
        end else if (load_en) begin
            count_d = (load_ext > AW'(CAPACITY)) ? CW'(CAPACITY) : load_val;
        end else begin
            count_d = CW'(count_next);
            rej_d   = rej_sum[REJ_W] ? '1 : rej_sum[REJ_W-1:0];
            if (exit_n > count_ext) begin
                uerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            rej_q   <= '0;
            uerr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            rej_q   <= rej_d;
            uerr_q  <= uerr_d;
        end
    end

    assign count         = count_q;
    assign rejected_cnt  = rej_q;
    assign underflow_err = uerr_q;
    assign full          = (count_q == CW'(CAPACITY));
    assign empty         = (count_q == '0);
    assign almost_full   = (count_ext >= AW'(ALMOST_TH));

endmodule

// File: tb/tb_parking_occupancy_counter.sv
module tb_parking_occupancy_counter;

    localparam int CAP = 99;
    localparam int NL  = 2;
    localparam int ATH = CAP - 5;
    localparam int CW  = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear, load_en;
    logic [CW-1:0] load_val;
    logic [NL-1:0] entry_req, exit_evt, entry_grant;
    logic [CW-1:0] count;
    logic          full, empty, almost_full;
    logic [15:0]   rejected_cnt;
    logic          underflow_err;

    parking_occupancy_counter #(
        .CAPACITY  (CAP),
        .N_LANES   (NL),
        .ALMOST_TH (ATH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .load_en       (load_en),
        .load_val      (load_val),
        .entry_req     (entry_req),
        .exit_evt      (exit_evt),
        .entry_grant   (entry_grant),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .rejected_cnt  (rejected_cnt),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit full;
        bit empty;
        bit af;
        int rej;
        bit uerr;
    } exp_t;

    logic [NL-1:0] grant_q[$];
    exp_t          state_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_count = 0;
    int m_rej   = 0;
    bit m_uerr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] model_step(input bit c, input bit l, input int lv,
                                                 input logic [NL-1:0] rq,
                                                 input logic [NL-1:0] ex);
        logic [NL-1:0] g;
        int ne, ve, free, k;
        g = '0;
        if (c) begin
            m_count = 0;
            m_rej   = 0;
            m_uerr  = 0;
        end else if (l) begin
            m_count = (lv > CAP) ? CAP : lv;
        end else begin
            ne   = $countones(ex);
            ve   = (ne < m_count) ? ne : m_count;
            if (ne > m_count) m_uerr = 1;
            free = CAP - m_count + ve;
            k    = 0;
            for (int i = 0; i < NL; i++) begin
                if (rq[i] && k < free) begin
                    g[i] = 1'b1;
                    k++;
                end
            end
            m_rej   = m_rej + ($countones(rq) - k);
            if (m_rej > 65535) m_rej = 65535;
            m_count = m_count - ve + k;
        end
        return g;
    endfunction

    task automatic drive(input bit c, input bit l, input int lv,
                         input logic [NL-1:0] rq, input logic [NL-1:0] ex);
        logic [NL-1:0] g;
        exp_t e;
        @(posedge clk);
        #2;
        clear     = c;
        load_en   = l;
        load_val  = lv[CW-1:0];
        entry_req = rq;
        exit_evt  = ex;
        g = model_step(c, l, lv, rq, ex);
        grant_q.push_back(g);
        e.cnt   = m_count;
        e.full  = (m_count == CAP);
        e.empty = (m_count == 0);
        e.af    = (m_count >= ATH);
        e.rej   = m_rej;
        e.uerr  = m_uerr;
        state_q.push_back(e);
    endtask

    // Stop driving and let the monitors consume everything outstanding.
    task automatic drain();
        @(posedge clk);
        #2;
        clear = 0; load_en = 0; load_val = '0; entry_req = '0; exit_evt = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("sb_grant_drained", grant_q.size(), 0);
        chk("sb_state_drained", state_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_rej"}, rejected_cnt, 0);
        chk({tag, "_uerr"}, underflow_err, 0);
        chk({tag, "_grant"}, entry_grant, 0);
    endtask

    // Grant monitor: the grant is combinational, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (grant_q.size() > 0) chk("grant", entry_grant, grant_q.pop_front());
        end
    end

    // State monitor: registered outputs just after the edge that produced them.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                chk("count", count, e.cnt);
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
                chk("almost_full", almost_full, e.af);
                chk("rejected_cnt", rejected_cnt, e.rej);
                chk("underflow_err", underflow_err, e.uerr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 0;
        clear = 0; load_en = 0; load_val = '0; entry_req = '0; exit_evt = '0;

        // Reset held: outputs pinned regardless of inputs and edges.
        #3;
        chk_reset_outputs("rst_hold");
        entry_req = 2'b11; exit_evt = 2'b01; load_val = 7'd50;
        #6;
        chk("rst_toggle_grant", entry_grant, 0);
        #8;
        chk("rst_toggle_count", count, 0);
        chk("rst_toggle_empty", empty, 1);
        entry_req = '0; exit_evt = '0; load_val = '0;
        #5;
        reset_n = 1;

        // Fill: 98 + two requests -> only lane 0 admitted.
        drive(0, 1, 98, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b11, 2'b00);
        #1;
        chk("fill_grant", entry_grant, 2'b01);
        drain();
        chk("fill_count", count, 99);
        chk("fill_full", full, 1);
        chk("fill_rej", rejected_cnt, 1);

        // Swap at full: exit on lane 1 frees a space for lane 0.
        drive(0, 0, 0, 2'b01, 2'b10);
        #1;
        chk("swap_grant", entry_grant, 2'b01);
        drain();
        chk("swap_count", count, 99);
        chk("swap_rej", rejected_cnt, 1);

        // Underflow: two exits with one car present.
        drive(0, 1, 1, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b00, 2'b11);
        drain();
        chk("uflow_count", count, 0);
        chk("uflow_err", underflow_err, 1);
        drive(0, 0, 0, 2'b01, 2'b00);
        drain();
        chk("uflow_sticky", underflow_err, 1);

        // Load clamps; clear beats load.
        drive(0, 1, 120, 2'b11, 2'b11);
        #1;
        chk("load_grant", entry_grant, 0);
        drain();
        chk("load_clamp", count, 99);
        drive(1, 1, 50, 2'b11, 2'b00);
        #1;
        chk("clear_grant", entry_grant, 0);
        drain();
        chk("clear_count", count, 0);
        chk("clear_rej", rejected_cnt, 0);
        chk("clear_uerr", underflow_err, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1, $urandom_range(0, 1), $urandom_range(0, 127), NL'($urandom), NL'($urandom));
            end else if (r < 7) begin
                drive(0, 1, $urandom_range(0, 127), NL'($urandom), NL'($urandom));
            end else begin
                drive(0, 0, 0, NL'($urandom),
                      ($urandom_range(0, 2) == 0) ? NL'($urandom) : NL'(0));
            end
        end
        drain();

        // Reset mid-operation discards the in-flight update.
        drive(0, 1, 10, 2'b00, 2'b00);
        drain();
        entry_req = 2'b11; exit_evt = 2'b01;
        #2;
        reset_n = 0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) begin
            @(negedge clk);
            entry_req = ~entry_req;
            load_en   = ~load_en;
        end
        #1;
        chk("rst_mid2_count", count, 0);
        chk("rst_mid2_grant", entry_grant, 0);
        @(negedge clk);
        entry_req = '0; exit_evt = '0; load_en = 0;
        reset_n = 1;
        m_count = 0; m_rej = 0; m_uerr = 0;
        drive(0, 0, 0, 2'b01, 2'b00);
        drain();
        chk("post_rst_count", count, 1);

        // Saturation: 32767 cycles of two rejections reach 0xFFFE.
        drive(1, 0, 0, 2'b00, 2'b00);
        drive(0, 1, 99, 2'b00, 2'b00);
        for (int i = 0; i < 32767; i++) drive(0, 0, 0, 2'b11, 2'b00);
        drain();
        chk("sat_pre", rejected_cnt, 16'hFFFE);
        drive(0, 0, 0, 2'b11, 2'b00);
        drain();
        chk("sat_hit", rejected_cnt, 16'hFFFF);
        drive(0, 0, 0, 2'b11, 2'b00);
        drain();
        chk("sat_hold", rejected_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
